// File: rtl/axil_simplebus_bridge.sv
// AXI-Lite slave terminated into single Simplebus master accesses, one transfer in flight.
// Writes have priority over reads; partial-strobe writes are refused and reads are time-bounded.
module axil_simplebus_bridge #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int unsigned READ_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] axi_awaddr,
  input  logic        axi_awvalid,
  output logic        axi_awready,
  input  logic [31:0] axi_wdata,
  input  logic [3:0]  axi_wstrb,
  input  logic        axi_wvalid,
  output logic        axi_wready,
  output logic [1:0]  axi_bresp,
  output logic        axi_bvalid,
  input  logic        axi_bready,
  input  logic [31:0] axi_araddr,
  input  logic        axi_arvalid,
  output logic        axi_arready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] sb_address,
  output logic [31:0] sb_write_data,
  output logic        sb_write_strobe,
  output logic        sb_read_strobe,
  input  logic        sb_ready,
  input  logic [31:0] sb_read_data,
  input  logic        sb_read_valid
);

  // state    | meaning
  // IDLE     | collecting AW/W, or accepting AR when no write is pending
  // WR_ISSUE | waiting for sb_ready, then one-cycle write strobe
  // WR_RESP  | BVALID held until BREADY
  // RD_ISSUE | waiting for sb_ready, then one-cycle read strobe
  // RD_WAIT  | waiting for sb_read_valid or the timeout terminal count
  // RD_RESP  | RVALID held until RREADY
  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP} state_t;

  localparam int unsigned CW = $clog2(READ_TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          run_q;
  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0]   awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   sb_address_d, sb_write_data_d, rdata_d;
  logic          sb_write_strobe_d, sb_read_strobe_d, bvalid_d, rvalid_d;
  logic [1:0]    bresp_d, rresp_d;
  logic          aw_hs, w_hs, ar_hs;
  logic [31:0]   aw_addr_eff, w_data_eff;
  logic [3:0]    w_strb_eff;

  // run_q keeps the ready outputs low until the first edge after reset release
  assign axi_awready = run_q && (state_q == IDLE) && !aw_held_q;
  assign axi_wready  = run_q && (state_q == IDLE) && !w_held_q;
  assign axi_arready = run_q && (state_q == IDLE) && !aw_held_q && !w_held_q
                       && !axi_awvalid && !axi_wvalid;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;
  assign ar_hs = axi_arvalid && axi_arready;

  assign aw_addr_eff = aw_held_q ? awaddr_q : axi_awaddr;
  assign w_data_eff  = w_held_q ? wdata_q : axi_wdata;
  assign w_strb_eff  = w_held_q ? wstrb_q : axi_wstrb;

  always_comb begin
    state_d           = state_q;
    aw_held_d         = aw_held_q;
    w_held_d          = w_held_q;
    awaddr_d          = awaddr_q;
    wdata_d           = wdata_q;
    wstrb_d           = wstrb_q;
    cnt_d             = cnt_q;
    sb_address_d      = sb_address;
    sb_write_data_d   = sb_write_data;
    sb_write_strobe_d = 1'b0;
    sb_read_strobe_d  = 1'b0;
    bvalid_d          = axi_bvalid;
    bresp_d           = axi_bresp;
    rvalid_d          = axi_rvalid;
    rresp_d           = axi_rresp;
    rdata_d           = axi_rdata;
    unique case (state_q)
      IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = axi_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = axi_wdata;
          wstrb_d  = axi_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (w_strb_eff == 4'hF) begin
            state_d           = WR_ISSUE;
            sb_address_d      = aw_addr_eff - BASE_ADDRESS;
            sb_write_data_d   = w_data_eff;
            sb_write_strobe_d = sb_ready;
          end else begin
            state_d  = WR_RESP;
            bvalid_d = 1'b1;
            bresp_d  = 2'b10;
          end
        end else if (ar_hs) begin
          state_d          = RD_ISSUE;
          sb_address_d     = axi_araddr - BASE_ADDRESS;
          sb_read_strobe_d = sb_ready;
        end
      end
      WR_ISSUE: begin
        if (sb_write_strobe) begin
          state_d  = WR_RESP;
          bvalid_d = 1'b1;
          bresp_d  = 2'b00;
        end else begin
          sb_write_strobe_d = sb_ready;
        end
      end
      WR_RESP: begin
        if (axi_bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      RD_ISSUE: begin
        if (sb_read_strobe) begin
          state_d = RD_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          sb_read_strobe_d = sb_ready;
        end
      end
      RD_WAIT: begin
        if (sb_read_valid) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rresp_d  = 2'b00;
          rdata_d  = sb_read_data;
        end else if (cnt_q == '0) begin
          state_d  = RD_RESP;
          rvalid_d = 1'b1;
          rresp_d  = 2'b10;
          rdata_d  = 32'h0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RD_RESP: begin
        if (axi_rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      run_q           <= 1'b0;
      aw_held_q       <= 1'b0;
      w_held_q        <= 1'b0;
      awaddr_q        <= 32'h0;
      wdata_q         <= 32'h0;
      wstrb_q         <= 4'h0;
      cnt_q           <= '0;
      sb_address      <= 32'h0;
      sb_write_data   <= 32'h0;
      sb_write_strobe <= 1'b0;
      sb_read_strobe  <= 1'b0;
      axi_bvalid      <= 1'b0;
      axi_bresp       <= 2'b00;
      axi_rvalid      <= 1'b0;
      axi_rresp       <= 2'b00;
      axi_rdata       <= 32'h0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      aw_held_q       <= aw_held_d;
      w_held_q        <= w_held_d;
      awaddr_q        <= awaddr_d;
      wdata_q         <= wdata_d;
      wstrb_q         <= wstrb_d;
      cnt_q           <= cnt_d;
      sb_address      <= sb_address_d;
      sb_write_data   <= sb_write_data_d;
      sb_write_strobe <= sb_write_strobe_d;
      sb_read_strobe  <= sb_read_strobe_d;
      axi_bvalid      <= bvalid_d;
      axi_bresp       <= bresp_d;
      axi_rvalid      <= rvalid_d;
      axi_rresp       <= rresp_d;
      axi_rdata       <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axil_simplebus_bridge.sv
// Bench for axil_simplebus_bridge: directed AXI-Lite transfers against a queue-based
// model of expected Simplebus accesses and AXI responses, plus latency and literal pins.
module tb_axil_simplebus_bridge;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] axi_awaddr = '0, axi_wdata = '0, axi_araddr = '0;
  logic        axi_awvalid = 1'b0, axi_wvalid = 1'b0, axi_arvalid = 1'b0;
  logic [3:0]  axi_wstrb = '0;
  logic        axi_bready = 1'b0, axi_rready = 1'b0;
  logic        axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid;
  logic [1:0]  axi_bresp, axi_rresp;
  logic [31:0] axi_rdata, sb_address, sb_write_data;
  logic        sb_write_strobe, sb_read_strobe;
  logic        sb_ready = 1'b1, sb_read_valid = 1'b0;
  logic [31:0] sb_read_data = '0;

  axil_simplebus_bridge #(.BASE_ADDRESS(BASE), .READ_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .sb_address(sb_address), .sb_write_data(sb_write_data),
    .sb_write_strobe(sb_write_strobe), .sb_read_strobe(sb_read_strobe),
    .sb_ready(sb_ready), .sb_read_data(sb_read_data), .sb_read_valid(sb_read_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } sb_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } r_t;
  sb_t        exp_sb[$];
  logic [1:0] exp_b[$];
  r_t         exp_r[$];

  int tests = 0, fails = 0, cyc = 0;
  int wstrobe_cnt = 0, rstrobe_cnt = 0, wstrobe_cyc = 0, rstrobe_cyc = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, ar_hs_cyc = 0, b_hs_cyc = 0, bvalid_rise = 0, rvalid_rise = 0;
  logic [31:0] last_wr_addr = '0, last_wr_data = '0, last_rd_addr = '0, last_rdata = '0;
  logic [1:0]  last_rresp = '0;
  logic        pb_valid = 1'b0, pb_ready = 1'b0, pr_valid = 1'b0, pr_ready = 1'b0;
  logic [1:0]  pb_resp = '0, pr_resp = '0;
  logic [31:0] pr_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] sb_of(input logic [31:0] a);
    return a - BASE;
  endfunction

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (s == 4'hF) begin
      exp_sb.push_back('{1'b1, sb_of(a), d});
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic expect_read(input logic [31:0] a, input logic [31:0] d, input logic timeout);
    exp_sb.push_back('{1'b0, sb_of(a), 32'h0});
    exp_r.push_back(timeout ? '{32'h0, 2'b10} : '{d, 2'b00});
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard and protocol checks, sampled mid-cycle
  always @(negedge clock) begin
    if (!reset) begin
      pb_valid <= 1'b0;
      pr_valid <= 1'b0;
    end else begin
      chk("strobe_excl", 32'(sb_write_strobe & sb_read_strobe), 32'h0);
      if (sb_write_strobe || sb_read_strobe) begin
        if (exp_sb.size() == 0) chk("sb_unexpected", 32'({sb_write_strobe, sb_read_strobe}), 32'h0);
        else begin
          chk("sb_kind", 32'(sb_write_strobe), 32'(exp_sb[0].wr));
          chk("sb_addr", sb_address, exp_sb[0].addr);
          if (exp_sb[0].wr) chk("sb_wdata", sb_write_data, exp_sb[0].data);
          void'(exp_sb.pop_front());
        end
        if (sb_write_strobe) begin
          wstrobe_cnt <= wstrobe_cnt + 1; wstrobe_cyc <= cyc;
          last_wr_addr <= sb_address; last_wr_data <= sb_write_data;
        end
        if (sb_read_strobe) begin
          rstrobe_cnt <= rstrobe_cnt + 1; rstrobe_cyc <= cyc; last_rd_addr <= sb_address;
        end
      end
      if (axi_awvalid && axi_awready) aw_hs_cyc <= cyc;
      if (axi_wvalid && axi_wready) w_hs_cyc <= cyc;
      if (axi_arvalid && axi_arready) ar_hs_cyc <= cyc;
      if (axi_bvalid && !pb_valid) bvalid_rise <= cyc;
      if (axi_rvalid && !pr_valid) rvalid_rise <= cyc;
      if (axi_bvalid && axi_bready) begin
        b_hs_cyc <= cyc;
        if (exp_b.size() == 0) chk("b_unexpected", 32'(axi_bvalid), 32'h0);
        else begin
          chk("bresp", 32'(axi_bresp), 32'(exp_b[0]));
          void'(exp_b.pop_front());
        end
      end
      if (axi_rvalid && axi_rready) begin
        last_rdata <= axi_rdata; last_rresp <= axi_rresp;
        if (exp_r.size() == 0) chk("r_unexpected", 32'(axi_rvalid), 32'h0);
        else begin
          chk("rdata", axi_rdata, exp_r[0].data);
          chk("rresp", 32'(axi_rresp), 32'(exp_r[0].resp));
          void'(exp_r.pop_front());
        end
      end
      if (pb_valid && !pb_ready) chk("b_hold", 32'({axi_bvalid, axi_bresp}), 32'({1'b1, pb_resp}));
      if (pr_valid && !pr_ready) begin
        chk("r_hold_data", axi_rdata, pr_data);
        chk("r_hold_ctrl", 32'({axi_rvalid, axi_rresp}), 32'({1'b1, pr_resp}));
      end
      if (axi_bvalid || axi_rvalid)
        chk("no_accept_in_resp", 32'({axi_awready, axi_wready, axi_arready}), 32'h0);
      pb_valid <= axi_bvalid; pb_ready <= axi_bready; pb_resp <= axi_bresp;
      pr_valid <= axi_rvalid; pr_ready <= axi_rready; pr_resp <= axi_rresp; pr_data <= axi_rdata;
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic sample_point();
    @(negedge clock); #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    axi_awaddr = a; axi_awvalid = 1'b1;
    @(negedge clock);
    while (!axi_awready && n < 100) begin @(negedge clock); n++; end
    if (!axi_awready) bound_fail("aw_handshake");
    tick();
    axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1;
    @(negedge clock);
    while (!axi_wready && n < 100) begin @(negedge clock); n++; end
    if (!axi_wready) bound_fail("w_handshake");
    tick();
    axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    axi_araddr = a; axi_arvalid = 1'b1;
    @(negedge clock);
    while (!axi_arready && n < 100) begin @(negedge clock); n++; end
    if (!axi_arready) bound_fail("ar_handshake");
    tick();
    axi_arvalid = 1'b0;
  endtask

  task automatic take_b(input int hold);
    int n = 0;
    axi_bready = 1'b0;
    @(negedge clock);
    while (!axi_bvalid && n < 200) begin @(negedge clock); n++; end
    if (!axi_bvalid) begin bound_fail("bvalid_wait"); return; end
    repeat (hold) tick();
    axi_bready = 1'b1;
    tick();
    axi_bready = 1'b0;
  endtask

  // late=1 pulses sb_read_valid with junk data while RVALID is being held
  task automatic take_r(input int hold, input logic late);
    int n = 0;
    axi_rready = 1'b0;
    @(negedge clock);
    while (!axi_rvalid && n < 200) begin @(negedge clock); n++; end
    if (!axi_rvalid) begin bound_fail("rvalid_wait"); return; end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (late) begin
        sb_read_valid = (i == 0);
        sb_read_data  = (i == 0) ? 32'hDEAD_BEEF : 32'h0;
      end
    end
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
  endtask

  task automatic slave_reply(input int delay, input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    while (!sb_read_strobe && n < 200) begin @(negedge clock); n++; end
    if (!sb_read_strobe) begin bound_fail("slave_strobe_wait"); return; end
    repeat (delay) tick();
    sb_read_valid = 1'b1; sb_read_data = d;
    tick();
    sb_read_valid = 1'b0; sb_read_data = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctrl"}, 32'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid,
                             sb_write_strobe, sb_read_strobe, axi_bresp, axi_rresp}), 32'h0);
    chk({tag, "_rdata"}, axi_rdata, 32'h0);
    chk({tag, "_sb_addr"}, sb_address, 32'h0);
    chk({tag, "_sb_wdata"}, sb_write_data, 32'h0);
  endtask

  initial begin
    int c0, rdy_cyc;
    repeat (2) @(posedge clock);
    sample_point();
    check_reset_outputs("reset");
    tick();
    reset = 1'b1;
    tick(); tick();
    sample_point();
    chk("idle_ready", 32'({axi_awready, axi_wready, axi_arready}), 32'h7);
    tick();

    // Aligned full-word write
    expect_write(32'h43C0_0010, 32'h1234_5678, 4'hF);
    fork send_aw(32'h43C0_0010); send_w(32'h1234_5678, 4'hF); join
    take_b(1);
    chk("wr_strobe_lat", 32'(wstrobe_cyc - aw_hs_cyc), 32'd1);
    chk("wr_b_lat", 32'(bvalid_rise - aw_hs_cyc), 32'd2);
    chk("wr_sb_addr_lit", last_wr_addr, 32'h0000_0010);
    chk("wr_sb_data_lit", last_wr_data, 32'h1234_5678);
    tick();

    // W leads AW by three cycles
    c0 = wstrobe_cnt;
    expect_write(32'h43C0_0020, 32'hA5A5_0001, 4'hF);
    send_w(32'hA5A5_0001, 4'hF);
    sample_point();
    chk("w_first_ready", 32'({axi_awready, axi_wready}), 32'h2);
    tick(); tick();
    send_aw(32'h43C0_0020);
    take_b(1);
    chk("w_first_gap", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
    chk("w_first_strobe_lat", 32'(wstrobe_cyc - aw_hs_cyc), 32'd1);
    chk("w_first_one_strobe", 32'(wstrobe_cnt - c0), 32'd1);
    chk("w_first_data_lit", last_wr_data, 32'hA5A5_0001);
    tick();

    // Read with four-cycle slave latency, RREADY held low for five cycles
    expect_read(32'h43C0_0008, 32'hCAFE_F00D, 1'b0);
    fork send_ar(32'h43C0_0008); slave_reply(4, 32'hCAFE_F00D); join
    take_r(5, 1'b0);
    chk("rd_strobe_lat", 32'(rstrobe_cyc - ar_hs_cyc), 32'd1);
    chk("rd_rvalid_lat", 32'(rvalid_rise - rstrobe_cyc), 32'd5);
    chk("rd_addr_lit", last_rd_addr, 32'h0000_0008);
    chk("rd_data_lit", last_rdata, 32'hCAFE_F00D);
    tick();

    // Silent slave: timeout, late valids ignored, then a normal read
    expect_read(32'h43C0_000C, 32'h0, 1'b1);
    send_ar(32'h43C0_000C);
    take_r(3, 1'b1);
    chk("to_lat", 32'(rvalid_rise - rstrobe_cyc), 32'd17);
    chk("to_rresp_lit", 32'(last_rresp), 32'h2);
    chk("to_rdata_lit", last_rdata, 32'h0);
    sb_read_valid = 1'b1; sb_read_data = 32'hBAD0_BAD0;
    tick();
    sb_read_valid = 1'b0; sb_read_data = 32'h0;
    tick();
    sample_point();
    chk("late_valid_idle", 32'(axi_rvalid), 32'h0);
    tick();
    expect_read(32'h43C0_0004, 32'h0BAD_CAFE, 1'b0);
    fork send_ar(32'h43C0_0004); slave_reply(2, 32'h0BAD_CAFE); join
    take_r(1, 1'b0);
    chk("after_to_lat", 32'(rvalid_rise - rstrobe_cyc), 32'd3);
    chk("after_to_data_lit", last_rdata, 32'h0BAD_CAFE);
    tick();

    // Partial strobe write is refused without a bus access
    c0 = wstrobe_cnt;
    expect_write(32'h43C0_0030, 32'h1111_2222, 4'h3);
    fork send_aw(32'h43C0_0030); send_w(32'h1111_2222, 4'h3); join
    take_b(2);
    chk("partial_no_strobe", 32'(wstrobe_cnt - c0), 32'd0);
    tick();

    // AW, W and AR together: write first, then read
    expect_write(32'h43C0_0040, 32'h55AA_55AA, 4'hF);
    expect_read(32'h43C0_0044, 32'h600D_F00D, 1'b0);
    fork
      send_aw(32'h43C0_0040);
      send_w(32'h55AA_55AA, 4'hF);
      send_ar(32'h43C0_0044);
      take_b(1);
      slave_reply(2, 32'h600D_F00D);
    join
    take_r(1, 1'b0);
    chk("prio_read_after_b", 32'(ar_hs_cyc > b_hs_cyc), 32'h1);
    chk("prio_read_data_lit", last_rdata, 32'h600D_F00D);
    tick();

    // Address below BASE wraps modulo 2^32
    expect_read(32'h0000_0004, 32'h1357_9BDF, 1'b0);
    fork send_ar(32'h0000_0004); slave_reply(1, 32'h1357_9BDF); join
    take_r(1, 1'b0);
    chk("wrap_addr_lit", last_rd_addr, 32'hBC40_0004);
    tick();

    // sb_ready low stalls writes and reads well past the read timeout
    sb_ready = 1'b0;
    c0 = wstrobe_cnt;
    expect_write(32'h43C0_0050, 32'h0000_0077, 4'hF);
    fork send_aw(32'h43C0_0050); send_w(32'h0000_0077, 4'hF); join
    repeat (25) tick();
    sample_point();
    chk("stall_wr_no_strobe", 32'(wstrobe_cnt - c0), 32'd0);
    chk("stall_wr_no_b", 32'(axi_bvalid), 32'h0);
    tick();
    sb_ready = 1'b1; rdy_cyc = cyc;
    take_b(1);
    chk("stall_wr_strobe_lat", 32'(wstrobe_cyc - rdy_cyc), 32'd1);
    tick();
    sb_ready = 1'b0;
    c0 = rstrobe_cnt;
    expect_read(32'h43C0_0060, 32'h0F0F_0F0F, 1'b0);
    fork
      slave_reply(1, 32'h0F0F_0F0F);
      begin
        send_ar(32'h43C0_0060);
        repeat (25) tick();
        sample_point();
        chk("stall_rd_no_strobe", 32'(rstrobe_cnt - c0), 32'd0);
        chk("stall_rd_no_rvalid", 32'(axi_rvalid), 32'h0);
        tick();
        sb_ready = 1'b1;
      end
    join
    take_r(1, 1'b0);
    chk("stall_rd_data_lit", last_rdata, 32'h0F0F_0F0F);
    tick();

    // Reset during RD_WAIT drops the read; the next read completes
    exp_sb.push_back('{1'b0, sb_of(32'h43C0_0018), 32'h0});
    send_ar(32'h43C0_0018);
    repeat (3) tick();
    #3 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    tick();
    check_reset_outputs("midrst_hold");
    reset = 1'b1;
    tick(); tick();
    expect_read(32'h43C0_001C, 32'h2468_ACE0, 1'b0);
    fork send_ar(32'h43C0_001C); slave_reply(2, 32'h2468_ACE0); join
    take_r(1, 1'b0);
    chk("post_rst_data_lit", last_rdata, 32'h2468_ACE0);
    tick(); tick();

    chk("sb_queue_drained", 32'(exp_sb.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
